// File: rtl/store_result_monitor.sv
`default_nettype none
// ============================================================================
// Module      : store_result_monitor
// Description : Registered pass/fail verdict monitor for the data-memory
//               write port of the pipelined MIPS core. Once armed it watches
//               every store. A store of PASS_DATA to PASS_ADDR passes. A
//               store to ALLOW_ADDR is legal scratch traffic and is counted.
//               Any other store fails. A watchdog fails the run if no store
//               arrives by the last permitted cycle.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   arm          in   leave IDLE and start monitoring
//   memwrite     in   data-memory write strobe from core
//   dataadr      in   [31:0] write address from core
//   writedata    in   [31:0] write data from core
//   done         out  verdict reached (sticky until reset)
//   pass         out  verdict is pass (valid while done=1)
//   fail_code    out  [1:0] 00 none, 01 illegal addr, 10 bad data, 11 timeout
//   store_count  out  [CNT_W-1:0] ALLOW_ADDR stores seen in RUN (saturating)
//   cycle_count  out  [CNT_W-1:0] clock edges spent in RUN (saturating)
//   last_adr     out  [31:0] address of most recent monitored store
//   last_data    out  [31:0] data of most recent monitored store
//
// Revision    : 1.0  initial release
// ============================================================================
module store_result_monitor #(
    parameter logic [31:0] PASS_ADDR      = 32'd84,
    parameter logic [31:0] PASS_DATA      = 32'd8781,
    parameter logic [31:0] ALLOW_ADDR     = 32'd80,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             memwrite,
    input  logic [31:0]      dataadr,
    input  logic [31:0]      writedata,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] store_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [31:0]      last_adr,
    output logic [31:0]      last_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [1:0] C_FC_NONE    = 2'b00;
    localparam logic [1:0] C_FC_ILLEGAL = 2'b01;
    localparam logic [1:0] C_FC_BADDATA = 2'b10;
    localparam logic [1:0] C_FC_TIMEOUT = 2'b11;

    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ALL_ONES  = '1;
    // Compared against the count *before* the edge, so the verdict lands on
    // the TIMEOUT_CYCLES-th RUN edge with cycle_count showing TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] C_LAST_EDGE = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state,      w_nextState;
    logic             r_done,       w_nextDone;
    logic             r_pass,       w_nextPass;
    logic [1:0]       r_failCode,   w_nextFailCode;
    logic [CNT_W-1:0] r_storeCount, w_nextStoreCount;
    logic [CNT_W-1:0] r_cycleCount, w_nextCycleCount;
    logic [31:0]      r_lastAdr,    w_nextLastAdr;
    logic [31:0]      r_lastData,   w_nextLastData;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_failCode   <= C_FC_NONE;
            r_storeCount <= '0;
            r_cycleCount <= '0;
            r_lastAdr    <= '0;
            r_lastData   <= '0;
        end else begin
            r_state      <= w_nextState;
            r_done       <= w_nextDone;
            r_pass       <= w_nextPass;
            r_failCode   <= w_nextFailCode;
            r_storeCount <= w_nextStoreCount;
            r_cycleCount <= w_nextCycleCount;
            r_lastAdr    <= w_nextLastAdr;
            r_lastData   <= w_nextLastData;
        end
    end

    always_comb begin
        // Default: hold everything. IDLE and the terminal states rely on this.
        w_nextState      = r_state;
        w_nextDone       = r_done;
        w_nextPass       = r_pass;
        w_nextFailCode   = r_failCode;
        w_nextStoreCount = r_storeCount;
        w_nextCycleCount = r_cycleCount;
        w_nextLastAdr    = r_lastAdr;
        w_nextLastData   = r_lastData;

        case (r_state)
            ST_IDLE: begin
                // A store on the arming edge is deliberately not monitored.
                if (arm) begin
                    w_nextState = ST_RUN;
                end
            end

            ST_RUN: begin
                if (r_cycleCount != C_ALL_ONES) begin
                    w_nextCycleCount = r_cycleCount + C_ONE;
                end

                if (memwrite) begin
                    w_nextLastAdr  = dataadr;
                    w_nextLastData = writedata;
                    // PASS_ADDR is checked first so that it wins if it is
                    // misconfigured to equal ALLOW_ADDR.
                    if (dataadr == PASS_ADDR) begin
                        w_nextDone = 1'b1;
                        if (writedata == PASS_DATA) begin
                            w_nextState    = ST_PASS;
                            w_nextPass     = 1'b1;
                            w_nextFailCode = C_FC_NONE;
                        end else begin
                            w_nextState    = ST_FAIL;
                            w_nextFailCode = C_FC_BADDATA;
                        end
                    end else if (dataadr == ALLOW_ADDR) begin
                        if (r_storeCount != C_ALL_ONES) begin
                            w_nextStoreCount = r_storeCount + C_ONE;
                        end
                    end else begin
                        w_nextState    = ST_FAIL;
                        w_nextDone     = 1'b1;
                        w_nextFailCode = C_FC_ILLEGAL;
                    end
                end else if (r_cycleCount == C_LAST_EDGE) begin
                    w_nextState    = ST_FAIL;
                    w_nextDone     = 1'b1;
                    w_nextFailCode = C_FC_TIMEOUT;
                end
            end

            default: begin
                // ST_PASS / ST_FAIL: terminal, everything frozen until reset.
            end
        endcase
    end

    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_code   = r_failCode;
    assign store_count = r_storeCount;
    assign cycle_count = r_cycleCount;
    assign last_adr    = r_lastAdr;
    assign last_data   = r_lastData;

endmodule
`default_nettype wire

// File: tb/tb_store_result_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_result_monitor
// Description : Directed self-checking bench for store_result_monitor, with
//               the watchdog shortened to 10 RUN cycles.
// Revision    : 1.0  initial release
// ============================================================================
module tb_store_result_monitor;

    localparam int C_CNT_W = 16;

    logic               clk;
    logic               reset;
    logic               arm;
    logic               memwrite;
    logic [31:0]        dataadr;
    logic [31:0]        writedata;
    logic               done;
    logic               pass;
    logic [1:0]         fail_code;
    logic [C_CNT_W-1:0] store_count;
    logic [C_CNT_W-1:0] cycle_count;
    logic [31:0]        last_adr;
    logic [31:0]        last_data;

    int nVec = 0;
    int nMis = 0;

    store_result_monitor #(
        .PASS_ADDR      (32'd84),
        .PASS_DATA      (32'd8781),
        .ALLOW_ADDR     (32'd80),
        .TIMEOUT_CYCLES (10),
        .CNT_W          (C_CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .arm         (arm),
        .memwrite    (memwrite),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .done        (done),
        .pass        (pass),
        .fail_code   (fail_code),
        .store_count (store_count),
        .cycle_count (cycle_count),
        .last_adr    (last_adr),
        .last_data   (last_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge; returns 1 time unit after it so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed strictly between edges.
    task automatic pulseReset();
        arm      = 1'b0;
        memwrite = 1'b0;
        reset    = 1'b0;
        #2;
        reset    = 1'b1;
    endtask

    task automatic armIt();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic doStore(input logic [31:0] adr, input logic [31:0] dat);
        memwrite  = 1'b1;
        dataadr   = adr;
        writedata = dat;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic test_reset();
        arm = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
        reset = 1'b0;
        #3;
        nVec++;
        if ({done, pass, fail_code} !== 4'b0000) begin
            nMis++;
            $display("FAIL reset_flags: got done=%b pass=%b fc=%b, want 0 0 00", done, pass, fail_code);
        end
        nVec++;
        if ({store_count, cycle_count, last_adr, last_data} !== 96'd0) begin
            nMis++;
            $display("FAIL reset_regs: got sc=%0d cc=%0d adr=%0d data=%0d, want all 0",
                     store_count, cycle_count, last_adr, last_data);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_pass();
        armIt();
        doStore(32'd80, 32'd7);
        doStore(32'd80, 32'd9);
        nVec++;
        if (done !== 1'b0 || store_count !== 16'd2) begin
            nMis++;
            $display("FAIL pass_midrun: got done=%b sc=%0d, want 0 2", done, store_count);
        end
        doStore(32'd84, 32'd8781);
        nVec++;
        if ({done, pass, fail_code} !== 4'b1100) begin
            nMis++;
            $display("FAIL pass_verdict: got done=%b pass=%b fc=%b, want 1 1 00", done, pass, fail_code);
        end
        nVec++;
        if (store_count !== 16'd2 || cycle_count !== 16'd3 || last_adr !== 32'd84 || last_data !== 32'd8781) begin
            nMis++;
            $display("FAIL pass_regs: got sc=%0d cc=%0d adr=%0d data=%0d, want 2 3 84 8781",
                     store_count, cycle_count, last_adr, last_data);
        end
    endtask

    task automatic test_wrong_data();
        pulseReset();
        armIt();
        doStore(32'd84, 32'd8780);
        nVec++;
        if ({done, pass, fail_code} !== 4'b1010 || last_data !== 32'd8780 || cycle_count !== 16'd1) begin
            nMis++;
            $display("FAIL baddata_verdict: got done=%b pass=%b fc=%b data=%0d cc=%0d, want 1 0 10 8780 1",
                     done, pass, fail_code, last_data, cycle_count);
        end
        arm = 1'b1;
        doStore(32'd84, 32'd8781);
        arm = 1'b0;
        tick();
        nVec++;
        if ({done, pass, fail_code} !== 4'b1010 || last_data !== 32'd8780 || cycle_count !== 16'd1) begin
            nMis++;
            $display("FAIL baddata_sticky: got done=%b pass=%b fc=%b data=%0d cc=%0d, want 1 0 10 8780 1",
                     done, pass, fail_code, last_data, cycle_count);
        end
    endtask

    task automatic test_illegal();
        pulseReset();
        armIt();
        doStore(32'd88, 32'd5);
        nVec++;
        if ({done, pass, fail_code} !== 4'b1001 || last_adr !== 32'd88 || last_data !== 32'd5 || store_count !== 16'd0) begin
            nMis++;
            $display("FAIL illegal: got done=%b pass=%b fc=%b adr=%0d data=%0d sc=%0d, want 1 0 01 88 5 0",
                     done, pass, fail_code, last_adr, last_data, store_count);
        end
    endtask

    task automatic test_timeout();
        pulseReset();
        armIt();
        for (int i = 0; i < 9; i++) tick();
        nVec++;
        if (done !== 1'b0 || cycle_count !== 16'd9) begin
            nMis++;
            $display("FAIL timeout_edge9: got done=%b cc=%0d, want 0 9", done, cycle_count);
        end
        tick();
        nVec++;
        if ({done, pass, fail_code} !== 4'b1011 || cycle_count !== 16'd10) begin
            nMis++;
            $display("FAIL timeout_edge10: got done=%b pass=%b fc=%b cc=%0d, want 1 0 11 10",
                     done, pass, fail_code, cycle_count);
        end
        tick();
        tick();
        nVec++;
        if ({done, fail_code} !== 3'b111 || cycle_count !== 16'd10) begin
            nMis++;
            $display("FAIL timeout_frozen: got done=%b fc=%b cc=%0d, want 1 11 10", done, fail_code, cycle_count);
        end
    endtask

    task automatic test_timeout_store();
        pulseReset();
        armIt();
        for (int i = 0; i < 9; i++) tick();
        doStore(32'd84, 32'd8781);
        nVec++;
        if ({done, pass, fail_code} !== 4'b1100 || cycle_count !== 16'd10) begin
            nMis++;
            $display("FAIL timeout_store: got done=%b pass=%b fc=%b cc=%0d, want 1 1 00 10",
                     done, pass, fail_code, cycle_count);
        end
    endtask

    task automatic test_idle_ignore();
        pulseReset();
        for (int i = 0; i < 5; i++) doStore(32'd88, 32'd1);
        nVec++;
        if (done !== 1'b0 || fail_code !== 2'b00 || store_count !== 16'd0 || cycle_count !== 16'd0 || last_adr !== 32'd0) begin
            nMis++;
            $display("FAIL idle_ignore: got done=%b fc=%b sc=%0d cc=%0d adr=%0d, want 0 00 0 0 0",
                     done, fail_code, store_count, cycle_count, last_adr);
        end
    endtask

    task automatic test_midrun_reset();
        pulseReset();
        armIt();
        for (int i = 0; i < 3; i++) doStore(32'd80, 32'(i + 20));
        nVec++;
        if (store_count !== 16'd3 || last_data !== 32'd22) begin
            nMis++;
            $display("FAIL midrun_setup: got sc=%0d data=%0d, want 3 22", store_count, last_data);
        end
        // Assert reset well clear of any edge and look before the next one.
        #1;
        reset = 1'b0;
        #1;
        nVec++;
        if ({done, pass, fail_code} !== 4'b0000 || {store_count, cycle_count, last_adr, last_data} !== 96'd0) begin
            nMis++;
            $display("FAIL midrun_async: got done=%b sc=%0d cc=%0d adr=%0d data=%0d, want all 0",
                     done, store_count, cycle_count, last_adr, last_data);
        end
        reset = 1'b1;
        tick();
        armIt();
        doStore(32'd80, 32'd1);
        doStore(32'd84, 32'd8781);
        nVec++;
        if ({done, pass, fail_code} !== 4'b1100 || store_count !== 16'd1 || cycle_count !== 16'd2) begin
            nMis++;
            $display("FAIL midrun_rearm: got done=%b pass=%b fc=%b sc=%0d cc=%0d, want 1 1 00 1 2",
                     done, pass, fail_code, store_count, cycle_count);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_wrong_data();
        test_illegal();
        test_timeout();
        test_timeout_store();
        test_idle_ignore();
        test_midrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire
